// File: rtl/mips_register_file_if.sv
// Register-file access bus for the single-cycle MIPS datapath.
// master : control unit / writeback side (drives addresses, write enable, data)
// slave  : the register file (returns the two read operands)
interface mips_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  reg_write;
    logic [ADDR_WIDTH-1:0] read_reg1;
    logic [ADDR_WIDTH-1:0] read_reg2;
    logic [ADDR_WIDTH-1:0] write_reg;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;

    modport master (
        output reg_write, read_reg1, read_reg2, write_reg, write_data,
        input  read_data1, read_data2
    );

    modport slave (
        input  reg_write, read_reg1, read_reg2, write_reg, write_data,
        output read_data1, read_data2
    );
endinterface

// File: rtl/mips_register_file.sv
// 32-entry MIPS general-purpose register file.
// Two combinational read ports (rs, rt), one synchronous write port.
// Register 0 is hard-wired to zero: writes to it are dropped, reads return 0.
// Optional feature macro: MIPS_REGFILE_BYPASS_EN
//   defined   -> a pending write is forwarded to a read port addressing the
//                same register in the same cycle (suppressed during reset)
//   undefined -> plain array read; a read sees the old value until the edge
module mips_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    mips_register_file_if.slave        bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic                  wr_en_s;
    logic [DATA_WIDTH-1:0] rd1_s;
    logic [DATA_WIDTH-1:0] rd2_s;

    // Qualified write enable: writes to register 0 are discarded
    always_comb begin
        wr_en_s = 1'b0;
        if (bus.reg_write && (bus.write_reg != '0)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Register array: async clear on reset, single write port on rising edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            regs_r[bus.write_reg] <= bus.write_data;
        end
    end

    // Read port 1 (rs): address 0 forced to zero, optional same-cycle forwarding
    always_comb begin
        rd1_s = '0;
        if (bus.read_reg1 == '0) begin
            rd1_s = '0;
        end else begin
            rd1_s = regs_r[bus.read_reg1];
`ifdef MIPS_REGFILE_BYPASS_EN
            if (reset_n && wr_en_s && (bus.read_reg1 == bus.write_reg)) begin
                rd1_s = bus.write_data;
            end else begin
                rd1_s = regs_r[bus.read_reg1];
            end
`endif
        end
    end

    // Read port 2 (rt): address 0 forced to zero, optional same-cycle forwarding
    always_comb begin
        rd2_s = '0;
        if (bus.read_reg2 == '0) begin
            rd2_s = '0;
        end else begin
            rd2_s = regs_r[bus.read_reg2];
`ifdef MIPS_REGFILE_BYPASS_EN
            if (reset_n && wr_en_s && (bus.read_reg2 == bus.write_reg)) begin
                rd2_s = bus.write_data;
            end else begin
                rd2_s = regs_r[bus.read_reg2];
            end
`endif
        end
    end

    assign bus.read_data1 = rd1_s;
    assign bus.read_data2 = rd2_s;

endmodule

// File: tb/tb_mips_register_file.sv
// Self-checking bench for mips_register_file: directed scenarios plus
// randomized traffic compared against an array-based reference model.
module tb_mips_register_file;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    logic [DW-1:0] model [32];

    mips_register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

    mips_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // What a read port must show right now, derived from the architectural rules
    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] addr);
        logic [DW-1:0] v;
        if (addr == 5'd0) return 32'd0;
        v = model[addr];
`ifdef MIPS_REGFILE_BYPASS_EN
        if (reset_n && bus_if.reg_write && bus_if.write_reg != 5'd0 && addr == bus_if.write_reg)
            v = bus_if.write_data;
`endif
        return v;
    endfunction

    task automatic check_reads(input string tag);
        check({tag, "_rd1"}, bus_if.read_data1, exp_read(bus_if.read_reg1));
        check({tag, "_rd2"}, bus_if.read_data2, exp_read(bus_if.read_reg2));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    // Advance one rising edge, updating the model with the write being presented
    task automatic tick();
        @(posedge clk);
        if (reset_n && bus_if.reg_write === 1'b1 && bus_if.write_reg != 5'd0)
            model[bus_if.write_reg] = bus_if.write_data;
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus_if.reg_write  = 1'b1;
        bus_if.write_reg  = a;
        bus_if.write_data = d;
        tick();
        bus_if.reg_write  = 1'b0;
    endtask

    task automatic set_reads(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        bus_if.read_reg1 = a1;
        bus_if.read_reg2 = a2;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_model();
        reset_n           = 1'b0;
        bus_if.reg_write  = 1'b0;
        bus_if.read_reg1  = 5'd5;
        bus_if.read_reg2  = 5'd31;
        bus_if.write_reg  = 5'd0;
        bus_if.write_data = 32'd0;

        // Reset state, and a write attempted while reset is held is ignored
        @(posedge clk); #1;
        check("reset_rd1", bus_if.read_data1, 32'd0);
        check("reset_rd2", bus_if.read_data2, 32'd0);
        bus_if.reg_write  = 1'b1;
        bus_if.write_reg  = 5'd4;
        bus_if.write_data = 32'hCAFE_F00D;
        tick();
        bus_if.reg_write  = 1'b0;
        #2 reset_n = 1'b1;
        set_reads(5'd4, 5'd4);
        check("write_in_reset", bus_if.read_data1, 32'd0);

        // Mid-cycle async reset clears a written register before the next edge
        do_write(5'd5, 32'hDEAD_BEEF);
        set_reads(5'd5, 5'd0);
        check("r5_written", bus_if.read_data1, 32'hDEAD_BEEF);
        #1 reset_n = 1'b0;
        clear_model();
        #1;
        check("async_reset_rd1", bus_if.read_data1, 32'd0);
        #1 reset_n = 1'b1;
        #1;
        check("after_release", bus_if.read_data1, 32'd0);
        tick();
        check("after_release_edge", bus_if.read_data1, 32'd0);

        // Basic write then read on both ports
        do_write(5'd8, 32'h1234_5678);
        set_reads(5'd8, 5'd8);
        check("basic_rd1", bus_if.read_data1, 32'h1234_5678);
        check("basic_rd2", bus_if.read_data2, 32'h1234_5678);

        // $zero discards writes
        do_write(5'd0, 32'hFFFF_FFFF);
        set_reads(5'd0, 5'd0);
        check("zero_rd1", bus_if.read_data1, 32'd0);
        check("zero_rd2", bus_if.read_data2, 32'd0);

        // Write disable
        do_write(5'd9, 32'h0000_0011);
        bus_if.reg_write  = 1'b0;
        bus_if.write_reg  = 5'd9;
        bus_if.write_data = 32'hAAAA_AAAA;
        tick();
        set_reads(5'd9, 5'd8);
        check("wr_disable", bus_if.read_data1, 32'h0000_0011);

        // X on write_reg with the enable low changes nothing
        bus_if.reg_write = 1'b0;
        bus_if.write_reg = 'x;
        bus_if.write_data = 32'h5555_5555;
        tick();
        bus_if.write_reg = 5'd0;
        set_reads(5'd9, 5'd8);
        check("x_addr_r9", bus_if.read_data1, 32'h0000_0011);
        check("x_addr_r8", bus_if.read_data2, 32'h1234_5678);

        // Same-cycle collision
        do_write(5'd3, 32'h0000_0001);
        bus_if.reg_write  = 1'b1;
        bus_if.write_reg  = 5'd3;
        bus_if.write_data = 32'h0000_0002;
        set_reads(5'd0, 5'd3);
`ifdef MIPS_REGFILE_BYPASS_EN
        check("collide_before", bus_if.read_data2, 32'h0000_0002);
`else
        check("collide_before", bus_if.read_data2, 32'h0000_0001);
`endif
        tick();
        bus_if.reg_write = 1'b0;
        #1;
        check("collide_after", bus_if.read_data2, 32'h0000_0002);

        // Full sweep: fill 1..31 with their address pattern, read pairs (k, 31-k)
        for (int a = 1; a < 32; a++) do_write(5'(a), 32'((a << 8) | a));
        for (int k = 0; k < 32; k++) begin
            set_reads(5'(k), 5'(31 - k));
            check("sweep_rd1", bus_if.read_data1, (k == 0) ? 32'd0 : 32'((k << 8) | k));
            check("sweep_rd2", bus_if.read_data2, (k == 31) ? 32'd0 : 32'(((31 - k) << 8) | (31 - k)));
        end

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            bus_if.reg_write  = 1'($urandom_range(0, 1));
            bus_if.write_reg  = 5'($urandom_range(0, 31));
            bus_if.write_data = $urandom;
            bus_if.read_reg1  = ($urandom_range(0, 3) == 0) ? bus_if.write_reg : 5'($urandom_range(0, 31));
            bus_if.read_reg2  = ($urandom_range(0, 3) == 0) ? bus_if.write_reg : 5'($urandom_range(0, 31));
            #1;
            check_reads("rand_pre");
            tick();
            bus_if.reg_write = 1'b0;
            #1;
            check_reads("rand_post");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
